seq_gen_bbcbc: RTL and testbench

Moore-model serial pattern generator that transmits the BBCBC sequence (B=0, C=1, bit stream 00101, first bit first) on a single-bit line, one bit per clock. It is the transmit side of the BBCBC pattern-detection path: it drives stimulus and link traffic into a BBCBC detector. A start/done handshake, a repetition count and a programmable idle gap between repetitions are provided. Every output is a registered function of state only.

---
 rtl/seq_pkg.sv | 29 ++
 rtl/seq_gen_bbcbc.sv | 129 ++++++++++++
 tb/tb_seq_gen_bbcbc.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: definitions shared by the BBCBC pattern generator and the BBCBC
// detector, so that both ends of the link agree on symbol values, the
// default pattern and the state encodings.
//   B, C            : line symbols (B = 0, C = 1)
//   DEF_PAT_LEN     : default pattern length in bits
//   DEF_PATTERN     : default pattern BBCBC, MSB transmitted first
//   ST_*            : one-hot state encodings
//   state_t         : generator state type built on those encodings
package seq_pkg;

  localparam logic B = 1'b0;
  localparam logic C = 1'b1;

  localparam int unsigned DEF_PAT_LEN = 5;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = {B, B, C, B, C};

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_SEND = 4'b0010;
  localparam logic [3:0] ST_GAP  = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  typedef enum logic [3:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/seq_gen_bbcbc.sv
// seq_gen_bbcbc: Moore serial generator for the BBCBC sequence. After an
// accepted start it sends the pattern count times (0 counts as 1), with gap
// idle-level cycles between repetitions, then pulses done for one cycle.
// All outputs are registers loaded with the values belonging to the state
// being entered, so nothing combinational reaches the pins.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, honoured in IDLE only
//   count : repetitions, latched on accepted start
//   gap   : idle cycles between repetitions, latched on accepted start
//   abort : abandons the current operation, no done pulse
//   d_out : serial data (IDLE_BIT when no pattern bit is driven)
//   d_vld : d_out carries a pattern bit
//   busy  : high in SEND and GAP
//   done  : one-cycle completion pulse
module seq_gen_bbcbc
  import seq_pkg::*;
#(
  parameter int unsigned          PAT_LEN  = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PATTERN  = DEF_PATTERN,
  parameter logic                 IDLE_BIT = C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] count,
  input  logic [3:0] gap,
  input  logic       abort,
  output logic       d_out,
  output logic       d_vld,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(PAT_LEN - 1);

  state_t     state;
  logic [2:0] bit_idx;
  logic [7:0] reps_left;
  logic [3:0] gap_cnt;
  logic [3:0] gap_lat;
  logic [2:0] bit_idx_dn;

  assign bit_idx_dn = bit_idx - 3'd1;

  // State register, counters and outputs in one block. Outputs default to
  // the idle line levels and each transition overrides them with the values
  // of the state it enters, which keeps them registered and aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= 3'd0;
      reps_left <= 8'd0;
      gap_cnt   <= 4'd0;
      gap_lat   <= 4'd0;
      d_out     <= IDLE_BIT;
      d_vld     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      d_out <= IDLE_BIT;
      d_vld <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // abort outranks start while idle
          if (start && !abort) begin
            reps_left <= (count == 8'd0) ? 8'd1 : count;
            gap_lat   <= gap;
            bit_idx   <= LAST_IDX;
            state     <= SEND;
            d_out     <= PATTERN[LAST_IDX];
            d_vld     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SEND: begin
          if (abort) begin
            state <= IDLE;
          end else if (bit_idx != 3'd0) begin
            bit_idx <= bit_idx_dn;
            d_out   <= PATTERN[bit_idx_dn];
            d_vld   <= 1'b1;
            busy    <= 1'b1;
          end else begin
            reps_left <= reps_left - 8'd1;
            if (reps_left == 8'd1) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (gap_lat == 4'd0) begin
              // zero gap: next repetition follows without a break
              bit_idx <= LAST_IDX;
              d_out   <= PATTERN[LAST_IDX];
              d_vld   <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= gap_lat;
              busy    <= 1'b1;
            end
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
            if (gap_cnt == 4'd1) begin
              state   <= SEND;
              bit_idx <= LAST_IDX;
              d_out   <= PATTERN[LAST_IDX];
              d_vld   <= 1'b1;
            end
            busy <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_bbcbc.sv
// tb_seq_gen_bbcbc: scoreboard bench for seq_gen_bbcbc. Each accepted start
// pushes the expected per-cycle output frames {d_out,d_vld,busy,done} into a
// queue; a monitor on the falling edge pops one frame per cycle (idle frame
// when the queue is empty) and compares it with the DUT outputs.
module tb_seq_gen_bbcbc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] count;
  logic [3:0] gap;
  logic       abort;
  logic       d_out;
  logic       d_vld;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [3:0] expQ[$];

  localparam logic [3:0] IDLE_FRAME = 4'b1000;

  always #5 clk = ~clk;

  seq_gen_bbcbc dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .count (count),
    .gap   (gap),
    .abort (abort),
    .d_out (d_out),
    .d_vld (d_vld),
    .busy  (busy),
    .done  (done)
  );

  task automatic checkOutput(input string name, input logic [3:0] got,
                             input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got {d_out,d_vld,busy,done}=%b, want %b",
               name, $time, got, want);
    end
  endtask

  // Reference model: the whole transmission, cycle by cycle.
  function automatic int pushExpected(input int n, input int g);
    logic [4:0] pat;
    int reps;
    int len;
    pat  = 5'b00101;
    reps = (n == 0) ? 1 : n;
    len  = 0;
    for (int r = 0; r < reps; r++) begin
      for (int i = 4; i >= 0; i--) begin
        expQ.push_back({pat[i], 1'b1, 1'b1, 1'b0});
        len++;
      end
      if (r < reps - 1) begin
        for (int k = 0; k < g; k++) begin
          expQ.push_back(4'b1010);
          len++;
        end
      end
    end
    expQ.push_back(4'b1001);
    return len + 1;
  endfunction

  // Monitor: one comparison per cycle, decoupled from the stimulus.
  always @(negedge clk) begin : monitor
    logic [3:0] want;
    want = (expQ.size() != 0) ? expQ.pop_front() : IDLE_FRAME;
    checkOutput("frame", {d_out, d_vld, busy, done}, want);
  end

  // Called just after a rising edge. abortAt < 0 means run to completion.
  task automatic applyStimulus(input int n, input int g, input int abortAt,
                               input bit poke);
    int t;
    #1;
    start = 1'b1;
    count = 8'(n);
    gap   = 4'(g);
    @(posedge clk);
    #1;
    start = 1'b0;
    count = 8'($urandom);
    gap   = 4'($urandom);
    void'(pushExpected(n, g));
    if (poke) begin
      start = 1'b1;
      count = 8'($urandom_range(2, 9));
      gap   = 4'($urandom_range(1, 5));
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (abortAt >= 0) begin
      repeat (abortAt) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      expQ.delete();
      @(posedge clk);
    end else begin
      t = 0;
      while (expQ.size() != 0 && t < 400) begin
        @(posedge clk);
        t++;
      end
      if (expQ.size() != 0) begin
        total++;
        bad++;
        $display("[TB] FAIL timeout: %0d frames still pending, want 0",
                 expQ.size());
        expQ.delete();
      end
    end
  endtask

  task automatic abortInIdle();
    #1;
    start = 1'b1;
    abort = 1'b1;
    count = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic resetMidSend();
    #1;
    start = 1'b1;
    count = 8'd2;
    gap   = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    void'(pushExpected(2, 1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst", {d_out, d_vld, busy, done}, IDLE_FRAME);
    expQ.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    int g;
    int mode;
    int len;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    count = 8'd0;
    gap   = 4'd0;
    #2;
    checkOutput("reset", {d_out, d_vld, busy, done}, IDLE_FRAME);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);

    applyStimulus(1, 0, -1, 1'b0);
    applyStimulus(3, 0, -1, 1'b0);
    applyStimulus(2, 2, -1, 1'b0);
    applyStimulus(0, 0, -1, 1'b1);
    applyStimulus(1, 0, 1, 1'b0);
    abortInIdle();
    resetMidSend();
    applyStimulus(1, 0, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      n    = $urandom_range(0, 4);
      g    = $urandom_range(0, 3);
      mode = $urandom_range(0, 3);
      len  = ((n == 0) ? 1 : n) * 5 + (((n == 0) ? 1 : n) - 1) * g + 1;
      if (mode == 0)
        applyStimulus(n, g, $urandom_range(0, len - 2), 1'b0);
      else if (mode == 1)
        applyStimulus(n, g, -1, 1'b1);
      else
        applyStimulus(n, g, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
